// File: rtl/bldc_mul_sched.sv
// Round-robin scheduler sharing one serial shift-add multiplier between phase duty requesters.
// Define BLDC_MUL_SCHED_DIV100_EN to append a serial divide-by-100 (duty = a*b/100).
module bldc_mul_sched #(
   parameter int NREQ  = 3,
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   a_bus,
   input  logic [NREQ*WIDTH-1:0]   b_bus,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic [2*WIDTH-1:0]      result,
   output logic                    busy
);

   // state  | meaning
   // S_IDLE | arbitrate among req, latch winner operands
   // S_MUL  | WIDTH shift-add steps, gnt pulses in the first one
   // S_DIV  | 2*WIDTH restoring steps dividing acc by 100
   // S_DONE | one cycle, done pulse for the winner
   localparam int PW = 2 * WIDTH;
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(PW);

`ifdef BLDC_MUL_SCHED_DIV100_EN
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_reg;
   logic [PW-1:0]    b_reg;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    acc_add;
   logic [IW-1:0]    ptr, win, win_nxt;
   logic             found;
   int               idx;

`ifdef BLDC_MUL_SCHED_DIV100_EN
   logic [6:0]       rem;
   logic [7:0]       rem_sh;
   logic [7:0]       rem_nxt;
   logic             q_bit;
   logic [PW-1:0]    acc_div;

   // acc doubles as the dividend shift register; quotient bits enter at the LSB
   always_comb begin
      rem_sh  = {rem, acc[PW-1]};
      q_bit   = (rem_sh >= 8'd100);
      rem_nxt = q_bit ? (rem_sh - 8'd100) : rem_sh;
      acc_div = {acc[PW-2:0], q_bit};
   end
`endif

   assign acc_add = acc + (a_reg[0] ? b_reg : '0);

   always_comb begin
      state_nxt = state;
      found     = 1'b0;
      win_nxt   = ptr;
      idx       = 0;
      gnt       = '0;
      done      = '0;
      busy      = (state != S_IDLE);
      for (int i = 1; i <= NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[IW'(idx)]) begin
            found   = 1'b1;
            win_nxt = IW'(idx);
         end
      end
      case (state)
         S_IDLE: if (enable && found) state_nxt = S_MUL;
         S_MUL: begin
            if (cnt == CW'(WIDTH - 1)) gnt[win] = 1'b1;
`ifdef BLDC_MUL_SCHED_DIV100_EN
            if (cnt == '0) state_nxt = S_DIV;
`else
            if (cnt == '0) state_nxt = S_DONE;
`endif
         end
`ifdef BLDC_MUL_SCHED_DIV100_EN
         S_DIV: if (cnt == '0) state_nxt = S_DONE;
`endif
         S_DONE: begin
            done[win] = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         acc    <= '0;
         result <= '0;
         win    <= '0;
         ptr    <= IW'(NREQ - 1);
`ifdef BLDC_MUL_SCHED_DIV100_EN
         rem    <= '0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (state_nxt == S_MUL) begin
                  a_reg <= a_bus[int'(win_nxt)*WIDTH +: WIDTH];
                  b_reg <= PW'(b_bus[int'(win_nxt)*WIDTH +: WIDTH]);
                  acc   <= '0;
                  win   <= win_nxt;
                  ptr   <= win_nxt;
                  cnt   <= CW'(WIDTH - 1);
`ifdef BLDC_MUL_SCHED_DIV100_EN
                  rem   <= '0;
`endif
               end
            end
            S_MUL: begin
               acc   <= acc_add;
               a_reg <= a_reg >> 1;
               b_reg <= b_reg << 1;
               cnt   <= cnt - 1'b1;
               if (cnt == '0) begin
`ifdef BLDC_MUL_SCHED_DIV100_EN
                  cnt <= CW'(PW - 1);
`else
                  result <= acc_add;
`endif
               end
            end
`ifdef BLDC_MUL_SCHED_DIV100_EN
            S_DIV: begin
               acc <= acc_div;
               rem <= rem_nxt[6:0];
               cnt <= cnt - 1'b1;
               if (cnt == '0) result <= acc_div;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bldc_mul_sched.sv
// Self-checking bench for bldc_mul_sched: vector table plus scoreboarded arbitration/reset/enable sequences.
module tb_bldc_mul_sched;
   localparam int NREQ = 3;
   localparam int W    = 8;
`ifdef BLDC_MUL_SCHED_DIV100_EN
   localparam int LAT  = 25;
`else
   localparam int LAT  = 9;
`endif

   logic              clk = 1'b0;
   logic              rst_n, enable;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] a_bus, b_bus;
   logic [NREQ-1:0]   gnt, done;
   logic [2*W-1:0]    result;
   logic              busy;

   bldc_mul_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
      .a_bus(a_bus), .b_bus(b_bus), .gnt(gnt), .done(done),
      .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {int ch; int a; int b; int r_div; int r_raw;} vec_t;
   typedef struct {int idx; int res;} exp_t;
   typedef struct {int idx; int res; int due;} pend_t;

   vec_t  vecs[7];
   exp_t  exp_q[$];
   pend_t pend[$];
   int    checks = 0, errors = 0;
   int    cyc = 0, gnt_cnt = 0, done_cnt = 0, req_cyc;
   int    gnt_hist[64];

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic int model(input int a, input int b);
`ifdef BLDC_MUL_SCHED_DIV100_EN
      return (a * b) / 100;
`else
      return a * b;
`endif
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (gnt != 0 && done != 0) chk("gnt_done_overlap", 1, 0);
         if (gnt != 0) begin
            if (exp_q.size() == 0) chk("unexpected_gnt", int'(gnt), 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("gnt_vector", int'(gnt), 1 << e.idx);
               chk("busy_at_gnt", int'(busy), 1);
               pend.push_back('{e.idx, e.res, cyc + LAT - 1});
            end
            if (gnt_cnt < 64) gnt_hist[gnt_cnt] = cyc;
            gnt_cnt++;
         end
         if (done != 0) begin
            if (pend.size() == 0) chk("unexpected_done", int'(done), 0);
            else begin
               pend_t p;
               p = pend.pop_front();
               chk("done_vector", int'(done), 1 << p.idx);
               chk("result", int'(result), p.res);
               chk("done_latency", cyc, p.due);
            end
            done_cnt++;
         end
      end
   end

   task automatic set_ops(input int ch, input int a, input int b);
      a_bus[ch*W +: W] = W'(a);
      b_bus[ch*W +: W] = W'(b);
   endtask

   task automatic wait_gnt(input int n, input int budget);
      for (int k = 0; k < budget && gnt_cnt < n; k++) @(posedge clk);
      chk("gnt_arrived", int'(gnt_cnt >= n), 1);
   endtask

   task automatic wait_done(input int n, input int budget);
      for (int k = 0; k < budget && done_cnt < n; k++) @(posedge clk);
      chk("done_arrived", int'(done_cnt >= n), 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; req = '0;
      @(posedge clk); #1;
      pend.delete();
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic run_op(input int ch, input int a, input int b, input int res);
      int g0, d0;
      @(posedge clk); #1;
      set_ops(ch, a, b);
      exp_q.push_back('{ch, res});
      g0 = gnt_cnt; d0 = done_cnt;
      req[ch] = 1'b1;
      req_cyc = cyc;
      wait_gnt(g0 + 1, 10);
      chk("gnt_latency", gnt_hist[g0 % 64], req_cyc + 1);
      #1 req = '0;
      wait_done(d0 + 1, LAT + 10);
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
   endtask

   initial begin
      int g0, d0;
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int g0, d0;
      rst_n = 1'b0; enable = 1'b1; req = '0; a_bus = '0; b_bus = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_gnt", int'(gnt), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_result", int'(result), 0);
      rst_n = 1'b1;

      vecs[0] = '{0, 254, 100, 254, 25400};
      vecs[1] = '{0, 255, 255, 650, 65025};
      vecs[2] = '{1,   0, 200,   0,     0};
      vecs[3] = '{2, 200,   0,   0,     0};
      vecs[4] = '{1, 127,  50,  63,  6350};
      vecs[5] = '{2,  99,   1,   0,    99};
      vecs[6] = '{0,  10,  10,   1,   100};
      foreach (vecs[i]) begin
`ifdef BLDC_MUL_SCHED_DIV100_EN
         run_op(vecs[i].ch, vecs[i].a, vecs[i].b, vecs[i].r_div);
`else
         run_op(vecs[i].ch, vecs[i].a, vecs[i].b, vecs[i].r_raw);
`endif
      end

      // round robin with all requests held: 0,1,2,0,1 back to back
      do_reset();
      set_ops(0, 127, 50); set_ops(1, 175, 50); set_ops(2, 37, 50);
      exp_q.push_back('{0, model(127, 50)});
      exp_q.push_back('{1, model(175, 50)});
      exp_q.push_back('{2, model(37, 50)});
      exp_q.push_back('{0, model(127, 50)});
      exp_q.push_back('{1, model(175, 50)});
      g0 = gnt_cnt; d0 = done_cnt;
      req = 3'b111;
      wait_gnt(g0 + 5, 5 * (LAT + 2) + 10);
      #1 req = '0;
      wait_done(d0 + 5, LAT + 10);
      for (int k = 0; k < 4; k++)
         chk("rr_spacing", gnt_hist[(g0 + k + 1) % 64] - gnt_hist[(g0 + k) % 64], LAT + 1);

      // reset during MUL aborts the operation
      @(posedge clk); #1;
      set_ops(0, 200, 200);
      exp_q.push_back('{0, model(200, 200)});
      g0 = gnt_cnt; d0 = done_cnt;
      req[0] = 1'b1;
      wait_gnt(g0 + 1, 10);
      #1 req = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      pend.delete();
      rst_n = 1'b1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_result", int'(result), 0);
      repeat (LAT + 5) @(posedge clk);
      chk("abort_no_done", done_cnt - d0, 0);

      run_op(1, 30, 40, model(30, 40));

      // pointer returns to NREQ-1 on reset, so req[0] beats req[1]
      do_reset();
      set_ops(0, 3, 200); set_ops(1, 150, 150);
      exp_q.push_back('{0, model(3, 200)});
      exp_q.push_back('{1, model(150, 150)});
      g0 = gnt_cnt; d0 = done_cnt;
      req = 3'b011;
      wait_gnt(g0 + 2, 2 * (LAT + 2) + 10);
      #1 req = '0;
      wait_done(d0 + 2, LAT + 10);

      // enable gating
      @(posedge clk); #1;
      enable = 1'b0;
      set_ops(2, 90, 80);
      g0 = gnt_cnt; d0 = done_cnt;
      req[2] = 1'b1;
      repeat (50) @(posedge clk);
      chk("gnt_while_disabled", gnt_cnt - g0, 0);
      chk("busy_while_disabled", int'(busy), 0);
      #1;
      exp_q.push_back('{2, model(90, 80)});
      enable = 1'b1;
      req_cyc = cyc;
      wait_gnt(g0 + 1, 10);
      chk("enable_gnt_latency", gnt_hist[g0 % 64], req_cyc + 1);
      #1 req = '0;
      repeat (2) @(posedge clk);
      #1 enable = 1'b0;
      wait_done(d0 + 1, LAT + 10);
      enable = 1'b1;

      repeat (3) @(posedge clk);
      chk("leftover_expectations", exp_q.size() + pend.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
